mouse_device_sm: RTL
====================

MOUSE_DEVICE_SM -- requirements
Module: mouse_device_sm

Interface
REQ-001 SHALL have parameter BOOT_DELAY, default 500000, meaning clock cycles from reset release to the power-on self-test report (10 ms at 50 MHz).
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port SEND_BYTE, output, 1 bit: one-cycle pulse requesting the byte transmitter to send BYTE_TO_SEND.
REQ-005 SHALL have port BYTE_TO_SEND, output, 8 bits: byte to transmit to the host.
REQ-006 SHALL have port BYTE_SENT, input, 1 bit: one-cycle pulse from the transmitter when the byte is done.
REQ-007 SHALL have port READ_ENABLE, output, 1 bit: enables the byte receiver.
REQ-008 SHALL have port BYTE_READY, input, 1 bit: one-cycle pulse when a host byte is received.
REQ-009 SHALL have port BYTE_READ, input, 8 bits: received host byte.
REQ-010 SHALL have port BYTE_ERROR_CODE, input, 2 bits: receive error; 00 means good.
REQ-011 SHALL have port PKT_VALID, input, 1 bit: the movement source has a packet.
REQ-012 SHALL have port PKT_STATUS/PKT_DX/PKT_DY, input, 8 bits each: packet contents.
REQ-013 SHALL have port PKT_READY, output, 1 bit: one-cycle pulse when the packet is captured.
REQ-014 SHALL have port STREAMING, output, 1 bit: data reporting is enabled.
REQ-015 SHALL have port current_state, output, 8 bits: one-hot state, for debug.

Function
REQ-016 SHALL use one-hot states: BOOT, CMD_WAIT, TX_LOAD, TX_WAIT, PKT_STATUS_TX, PKT_DX_TX, PKT_DY_TX, HOLD.
REQ-017 BOOT: count to BOOT_DELAY-1, then queue the reply sequence AA,00 and go to TX_LOAD; STREAMING=0.
REQ-018 Transmit handshake: TX_LOAD drives SEND_BYTE=1 for exactly one cycle with BYTE_TO_SEND valid that cycle; BYTE_TO_SEND is held until BYTE_SENT; TX_WAIT waits for BYTE_SENT; there is no timeout.
REQ-019 A reply queue of up to 3 bytes; after BYTE_SENT, the next queued byte goes to TX_LOAD on the following cycle; an empty queue returns to CMD_WAIT.
REQ-020 CMD_WAIT: on BYTE_READY with error code 00, decode the command. FF → queue FA,AA,00 and STREAMING←0. F4 → queue FA and STREAMING←1. F5 → queue FA and STREAMING←0. F2 → queue FA,00. Any other byte → queue FA and ignore the byte.
REQ-021 A BYTE_READY with nonzero BYTE_ERROR_CODE in any state SHALL queue a single FE (resend), abort any packet in progress, and leave STREAMING unchanged.
REQ-022 CMD_WAIT with STREAMING=1, PKT_VALID=1 and no BYTE_READY that cycle: capture the three packet bytes, pulse PKT_READY, then go to PKT_STATUS_TX.
REQ-023 Packet bytes are sent in the order status, dx, dy, each using the REQ-018 handshake, then the FSM returns to CMD_WAIT.
REQ-024 When BYTE_READY and PKT_VALID arrive in the same cycle, the command wins; PKT_READY is not pulsed and the packet stays pending.
REQ-025 A good host byte received during packet transmission aborts the remaining packet bytes after the current BYTE_SENT, and the command is then handled per REQ-020.
REQ-026 READ_ENABLE SHALL be 1 only in CMD_WAIT and HOLD, and 0 from TX_LOAD until the final BYTE_SENT of a sequence; BYTE_READY while READ_ENABLE=0 is still honoured.
REQ-027 HOLD is reserved and SHALL go to CMD_WAIT next cycle; any illegal state SHALL go to BOOT.

Reset
REQ-028 RESET=0 SHALL immediately give: state BOOT, counter 0, queue empty, SEND_BYTE=0, BYTE_TO_SEND=00, READ_ENABLE=0, PKT_READY=0, STREAMING=0.
REQ-029 Reset asserted mid-transmit or mid-packet SHALL abort it with no further SEND_BYTE; BOOT restarts fully after release.

Verification
REQ-030 Reset released, BOOT_DELAY=100 → SEND_BYTE at cycle 100 with AA; after BYTE_SENT, SEND_BYTE with 00; then CMD_WAIT, READ_ENABLE=1.
REQ-031 In CMD_WAIT, host FF → FA, AA, 00 in order, one SEND_BYTE per BYTE_SENT, STREAMING=0.
REQ-032 Host F4 → FA, STREAMING=1; then PKT_VALID with 08/05/FB → PKT_READY pulse, bytes 08, 05, FB sent.
REQ-033 BYTE_READY with error code 01 during CMD_WAIT → single FE; STREAMING unchanged.
REQ-034 BYTE_READY (F5) in the same cycle as PKT_VALID → FA sent, no PKT_READY, STREAMING=0.
REQ-035 RESET pulsed between the dx and dy bytes → no further SEND_BYTE; after BOOT_DELAY, AA then 00.

Source files
------------

// File: rtl/mouse_device_sm.sv
// mouse_device_sm: PS/2 mouse device-side protocol state machine.
// Boots with a self-test report (AA,00), decodes host commands, replies via a
// short reply queue, and streams 3-byte movement packets when enabled.
// Ports:
//   CLK             system clock, rising edge
//   RESET           asynchronous active-low reset
//   SEND_BYTE       one-cycle request to the byte transmitter
//   BYTE_TO_SEND    byte for the transmitter, held until BYTE_SENT
//   BYTE_SENT       transmitter done pulse
//   READ_ENABLE     enables the byte receiver (CMD_WAIT / HOLD only)
//   BYTE_READY      received host byte pulse
//   BYTE_READ       received host byte
//   BYTE_ERROR_CODE receive error code, 00 = good
//   PKT_VALID       movement source has a packet
//   PKT_STATUS/DX/DY packet contents
//   PKT_READY       one-cycle pulse when the packet is captured
//   STREAMING       data reporting enabled
//   current_state   one-hot state for debug
module mouse_device_sm #(
    parameter int BOOT_DELAY = 500000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic       BYTE_READY,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       PKT_VALID,
    input  logic [7:0] PKT_STATUS,
    input  logic [7:0] PKT_DX,
    input  logic [7:0] PKT_DY,
    output logic       PKT_READY,
    output logic       STREAMING,
    output logic [7:0] current_state
);
    localparam logic [7:0] S_BOOT      = 8'h01;
    localparam logic [7:0] S_CMD_WAIT  = 8'h02;
    localparam logic [7:0] S_TX_LOAD   = 8'h04;
    localparam logic [7:0] S_TX_WAIT   = 8'h08;
    localparam logic [7:0] S_PKT_STAT  = 8'h10;
    localparam logic [7:0] S_PKT_DX    = 8'h20;
    localparam logic [7:0] S_PKT_DY    = 8'h40;
    localparam logic [7:0] S_HOLD      = 8'h80;
    localparam logic [31:0] LAST       = 32'(BOOT_DELAY - 1);

    logic [7:0]  state, next_state;
    logic [31:0] cnt;
    logic [7:0]  q0, q1;
    logic [1:0]  qn;
    logic [7:0]  dx_r, dy_r;
    logic        pend;
    logic [7:0]  pend_byte;
    logic [1:0]  pend_err;
    logic        sent_req;
    logic        streaming_r;

    logic        host;
    logic [7:0]  h_byte;
    logic [1:0]  h_err;
    logic [7:0]  r0, r1, r2;
    logic [1:0]  rn;
    logic        r_stream;
    logic        boot_done, load_reply, pop, capture, pkt_adv, is_pkt;

    // A host byte is either arriving now or was latched while the FSM was busy;
    // a fresh byte takes precedence over the latched one.
    assign host   = BYTE_READY | pend;
    assign h_byte = BYTE_READY ? BYTE_READ : pend_byte;
    assign h_err  = BYTE_READY ? BYTE_ERROR_CODE : pend_err;
    assign is_pkt = (state == S_PKT_STAT) || (state == S_PKT_DX) || (state == S_PKT_DY);

    // Command decode: r0 is sent first, r1/r2 follow, rn is the reply length.
    always_comb begin
        r0       = 8'hFA;
        r1       = 8'h00;
        r2       = 8'h00;
        rn       = 2'd1;
        r_stream = streaming_r;
        if (h_err != 2'b00) begin
            r0 = 8'hFE;
        end else if (h_byte == 8'hFF) begin
            r1       = 8'hAA;
            rn       = 2'd3;
            r_stream = 1'b0;
        end else if (h_byte == 8'hF4) begin
            r_stream = 1'b1;
        end else if (h_byte == 8'hF5) begin
            r_stream = 1'b0;
        end else if (h_byte == 8'hF2) begin
            rn = 2'd2;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_BOOT;
        else        state <= next_state;
    end

    // Next-state logic and datapath controls
    always_comb begin
        next_state = state;
        boot_done  = 1'b0;
        load_reply = 1'b0;
        pop        = 1'b0;
        capture    = 1'b0;
        pkt_adv    = 1'b0;
        case (state)
            S_BOOT: begin
                if (cnt == LAST) begin
                    boot_done  = 1'b1;
                    next_state = S_TX_LOAD;
                end
            end
            S_CMD_WAIT: begin
                if (host) begin
                    load_reply = 1'b1;
                    next_state = S_TX_LOAD;
                end else if (streaming_r && PKT_VALID) begin
                    capture    = 1'b1;
                    next_state = S_PKT_STAT;
                end
            end
            S_TX_LOAD: next_state = S_TX_WAIT;
            S_TX_WAIT: begin
                if (BYTE_SENT) begin
                    if (qn != 2'd0) begin
                        pop        = 1'b1;
                        next_state = S_TX_LOAD;
                    end else if (host) begin
                        load_reply = 1'b1;
                        next_state = S_TX_LOAD;
                    end else begin
                        next_state = S_CMD_WAIT;
                    end
                end
            end
            S_PKT_STAT, S_PKT_DX, S_PKT_DY: begin
                // A host byte abandons the rest of the packet once the
                // byte currently on the wire completes.
                if (BYTE_SENT && sent_req) begin
                    if (host) begin
                        load_reply = 1'b1;
                        next_state = S_TX_LOAD;
                    end else if (state == S_PKT_STAT) begin
                        pkt_adv    = 1'b1;
                        next_state = S_PKT_DX;
                    end else if (state == S_PKT_DX) begin
                        pkt_adv    = 1'b1;
                        next_state = S_PKT_DY;
                    end else begin
                        next_state = S_CMD_WAIT;
                    end
                end
            end
            S_HOLD:  next_state = S_CMD_WAIT;
            default: next_state = S_BOOT;
        endcase
    end

    // Outputs
    always_comb begin
        SEND_BYTE     = (state == S_TX_LOAD) || (is_pkt && !sent_req);
        READ_ENABLE   = (state == S_CMD_WAIT) || (state == S_HOLD);
        PKT_READY     = capture;
        STREAMING     = streaming_r;
        current_state = state;
    end

    // Datapath: boot counter, reply queue, packet capture, pending host byte.
    // BYTE_TO_SEND holds the byte in flight; q0/q1 hold the bytes after it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt          <= '0;
            BYTE_TO_SEND <= 8'h00;
            q0           <= 8'h00;
            q1           <= 8'h00;
            qn           <= 2'd0;
            dx_r         <= 8'h00;
            dy_r         <= 8'h00;
            pend         <= 1'b0;
            pend_byte    <= 8'h00;
            pend_err     <= 2'b00;
            sent_req     <= 1'b0;
            streaming_r  <= 1'b0;
        end else begin
            cnt      <= (state == S_BOOT) ? cnt + 32'd1 : '0;
            sent_req <= is_pkt && (next_state == state);
            pend     <= (BYTE_READY || pend) && !load_reply;
            if (BYTE_READY) begin
                pend_byte <= BYTE_READ;
                pend_err  <= BYTE_ERROR_CODE;
            end
            if (boot_done) begin
                BYTE_TO_SEND <= 8'hAA;
                q0           <= 8'h00;
                qn           <= 2'd1;
                streaming_r  <= 1'b0;
            end else if (load_reply) begin
                BYTE_TO_SEND <= r0;
                q0           <= r1;
                q1           <= r2;
                qn           <= rn - 2'd1;
                streaming_r  <= r_stream;
            end else if (pop) begin
                BYTE_TO_SEND <= q0;
                q0           <= q1;
                qn           <= qn - 2'd1;
            end else if (capture) begin
                BYTE_TO_SEND <= PKT_STATUS;
                dx_r         <= PKT_DX;
                dy_r         <= PKT_DY;
            end else if (pkt_adv) begin
                BYTE_TO_SEND <= (next_state == S_PKT_DX) ? dx_r : dy_r;
            end
        end
    end
endmodule
